// File: rtl/au_sub_cz_seq.sv
// Digit-serial subtractor: accepts a, b, ci, then resolves DW bits per cycle,
// producing difference, borrow-out and a zero flag over the full {co, s} result.
module au_sub_cz_seq #(
    parameter int WIDTH = 8,
    parameter int DW    = 4,
    parameter int ARCH  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             z
);

    localparam int N  = (WIDTH + DW - 1) / DW;
    localparam int NW = N * DW;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    // Marks the real operand bits inside the zero-padded digit vector.
    localparam logic [NW-1:0] MASK = {NW{1'b1}} >> (NW - WIDTH);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "au_sub_cz_seq: illegal WIDTH=%0d", WIDTH);
    end
    if (DW < 1 || DW > WIDTH) begin : g_bad_dw
        $fatal(1, "au_sub_cz_seq: illegal DW=%0d", DW);
    end
    if (ARCH < 0 || ARCH > 2) begin : g_bad_arch
        $fatal(1, "au_sub_cz_seq: illegal ARCH=%0d", ARCH);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [NW-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic             borrow_q, borrow_d, zacc_q, zacc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d, z_q, z_d;

    logic [DW:0]      diff_s;
    logic [DW-1:0]    dmask_s;
    logic [NW-1:0]    diff_ext_s, res_nxt_s;
    logic             zacc_nxt_s;

    // Current digit: operands are shifted down so digit k always sits at bit 0.
    always_comb begin
        diff_s     = {1'b0, a_q[DW-1:0]} - {1'b0, b_q[DW-1:0]} - {{DW{1'b0}}, borrow_q};
        dmask_s    = DW'(MASK >> (DW * int'(cnt_q)));
        diff_ext_s = '0;
        diff_ext_s[NW-1 -: DW] = diff_s[DW-1:0];
        res_nxt_s  = (res_q >> DW) | diff_ext_s;
        zacc_nxt_s = zacc_q & ((diff_s[DW-1:0] & dmask_s) == {DW{1'b0}});
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        zacc_d   = zacc_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        co_d     = co_q;
        z_d      = z_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    a_d      = NW'(a);
                    b_d      = NW'(b);
                    borrow_d = ci;
                    cnt_d    = '0;
                    zacc_d   = 1'b1;
                    res_d    = '0;
                    state_d  = CALC;
                end else begin
                    state_d  = IDLE;
                end
            end
            CALC: begin
                a_d      = a_q >> DW;
                b_d      = b_q >> DW;
                res_d    = res_nxt_s;
                borrow_d = diff_s[DW];
                zacc_d   = zacc_nxt_s;
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    s_d     = res_nxt_s[WIDTH-1:0];
                    co_d    = diff_s[DW];
                    z_d     = zacc_nxt_s & ~diff_s[DW];
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = CALC;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            zacc_q   <= 1'b0;
            cnt_q    <= '0;
            s_q      <= '0;
            co_q     <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            zacc_q   <= zacc_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            co_q     <= co_d;
            z_q      <= z_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign s       = s_q;
    assign co      = co_q;
    assign z       = z_q;

endmodule

// File: tb/tb_au_sub_cz_seq.sv
// Directed and randomized checks of au_sub_cz_seq at (8,4), (7,3) and (1,1).
module tb_au_sub_cz_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       v8, r8, c8, rdy8, vo8, co8, z8;
    logic [7:0] a8, b8, s8;
    logic       v7, r7, c7, rdy7, vo7, co7, z7;
    logic [6:0] a7, b7, s7;
    logic       v1, r1, c1, rdy1, vo1, co1, z1;
    logic [0:0] a1, b1, s1;

    int vectors = 0;
    int miscompares = 0;

    au_sub_cz_seq #(.WIDTH(8), .DW(4), .ARCH(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .valid_i(v8), .ready_o(rdy8), .a(a8), .b(b8), .ci(c8),
        .valid_o(vo8), .ready_i(r8), .s(s8), .co(co8), .z(z8));
    au_sub_cz_seq #(.WIDTH(7), .DW(3), .ARCH(1)) dut7 (
        .clk(clk), .rst_n(rst_n), .valid_i(v7), .ready_o(rdy7), .a(a7), .b(b7), .ci(c7),
        .valid_o(vo7), .ready_i(r7), .s(s7), .co(co7), .z(z7));
    au_sub_cz_seq #(.WIDTH(1), .DW(1), .ARCH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .valid_i(v1), .ready_o(rdy1), .a(a1), .b(b1), .ci(c1),
        .valid_o(vo1), .ready_i(r1), .s(s1), .co(co1), .z(z1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one operation on the 8-bit instance and leaves it waiting in DONE.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic eco, input logic ez);
        @(negedge clk); v8 = 1'b1; a8 = a; b8 = b; c8 = c;
        @(negedge clk); v8 = 1'b0; a8 = ~a; b8 = 8'($urandom); c8 = ~c;
        check({tag, ".ready_busy"}, 32'(rdy8), 32'd0);
        check({tag, ".valid_e0"}, 32'(vo8), 32'd0);
        @(negedge clk);
        check({tag, ".valid_e1"}, 32'(vo8), 32'd0);
        @(negedge clk);
        check({tag, ".valid_e2"}, 32'(vo8), 32'd1);
        check({tag, ".s"}, 32'(s8), 32'(es));
        check({tag, ".co"}, 32'(co8), 32'(eco));
        check({tag, ".z"}, 32'(z8), 32'(ez));
    endtask

    task automatic release8(input string tag);
        r8 = 1'b1;
        @(negedge clk); r8 = 1'b0;
        check({tag, ".valid_rel"}, 32'(vo8), 32'd0);
        check({tag, ".ready_rel"}, 32'(rdy8), 32'd1);
    endtask

    task automatic rand7(input int n);
        logic [7:0] e;
        logic [6:0] ra, rb;
        logic       rc;
        int         lat;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk); v7 = 1'b0; a7 = 7'($urandom); b7 = 7'($urandom);
            end
            ra = 7'($urandom); rb = 7'($urandom); rc = 1'($urandom);
            e  = {1'b0, ra} - {1'b0, rb} - {7'd0, rc};
            @(negedge clk); v7 = 1'b1; a7 = ra; b7 = rb; c7 = rc;
            @(negedge clk); v7 = 1'($urandom); a7 = 7'($urandom); b7 = 7'($urandom); c7 = 1'($urandom);
            lat = 0;
            while (!vo7 && lat < 8) begin
                @(negedge clk); lat++;
                v7 = 1'($urandom); a7 = 7'($urandom);
            end
            check("w7.latency", 32'(lat), 32'd3);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk); v7 = 1'($urandom); a7 = 7'($urandom);
            end
            check("w7.valid", 32'(vo7), 32'd1);
            check("w7.s", 32'(s7), 32'(e[6:0]));
            check("w7.co", 32'(co7), 32'(e[7]));
            check("w7.z", 32'(z7), 32'(e == 8'd0));
            v7 = 1'b0; r7 = 1'b1;
            @(negedge clk); r7 = 1'b0;
        end
    endtask

    task automatic rand1(input int n);
        logic [1:0] e;
        logic       ra, rb, rc;
        int         lat;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk); v1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom);
            end
            ra = 1'($urandom); rb = 1'($urandom); rc = 1'($urandom);
            e  = {1'b0, ra} - {1'b0, rb} - {1'b0, rc};
            @(negedge clk); v1 = 1'b1; a1 = ra; b1 = rb; c1 = rc;
            @(negedge clk); v1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
            lat = 0;
            while (!vo1 && lat < 6) begin
                @(negedge clk); lat++;
            end
            check("w1.latency", 32'(lat), 32'd1);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk); v1 = 1'($urandom); a1 = 1'($urandom);
            end
            check("w1.s", 32'(s1), 32'(e[0]));
            check("w1.co", 32'(co1), 32'(e[1]));
            check("w1.z", 32'(z1), 32'(e == 2'd0));
            v1 = 1'b0; r1 = 1'b1;
            @(negedge clk); r1 = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {v8, r8, c8, a8, b8} = '0;
        {v7, r7, c7, a7, b7} = '0;
        {v1, r1, c1, a1, b1} = '0;
        #2;
        check("rst.ready", 32'(rdy8), 32'd1);
        check("rst.valid", 32'(vo8), 32'd0);
        check("rst.s", 32'(s8), 32'd0);
        check("rst.co", 32'(co8), 32'd0);
        check("rst.z", 32'(z8), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        op8("v05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0); release8("v05_03");
        op8("v03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0); release8("v03_05");
        op8("v10_0F", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1); release8("v10_0F");
        op8("vFF_FF", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1); release8("vFF_FF");
        op8("vFF_00", 8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0); release8("vFF_00");
        op8("v00_00", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) begin
            v8 = 1'(i % 2 == 0); a8 = 8'h55; b8 = 8'h11; c8 = 1'b0;
            @(negedge clk);
            check("hold.valid", 32'(vo8), 32'd1);
            check("hold.ready", 32'(rdy8), 32'd0);
            check("hold.s", 32'(s8), 32'hFF);
            check("hold.co", 32'(co8), 32'd1);
            check("hold.z", 32'(z8), 32'd0);
        end
        v8 = 1'b0;
        release8("hold");
        @(negedge clk);
        check("hold.nocapture", 32'(rdy8), 32'd1);

        op8("v80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0); release8("v80_01");
        @(negedge clk); v8 = 1'b1; a8 = 8'hA5; b8 = 8'h5A; c8 = 1'b0;
        @(negedge clk); v8 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midrst.ready", 32'(rdy8), 32'd1);
        check("midrst.valid", 32'(vo8), 32'd0);
        check("midrst.s", 32'(s8), 32'd0);
        check("midrst.co", 32'(co8), 32'd0);
        check("midrst.z", 32'(z8), 32'd0);
        #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("midrst.nostale", 32'(vo8), 32'd0);
        end
        op8("post_rst", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0); release8("post_rst");

        rand7(1000);
        rand1(1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
